// File: rtl/clock_period_meter.sv
// -----------------------------------------------------------------------------
// clock_period_meter
//
// Measures a slow signal that is asynchronous to the system clock, such as a
// divided clock or a periodic tick. The result is reported in Clock_in cycles.
// Each measurement gives the period between two consecutive rising edges of
// Sig_in and the number of cycles Sig_in was high within that period.
//
// Parameters
//   SYNC_STAGES    : flip-flop stages in the Sig_in synchronizer (>= 2)
//   TIMEOUT_CYCLES : cycles without a rising edge before Timeout is raised
//   W              : counter / result width, $clog2(TIMEOUT_CYCLES+1)
//
// Ports
//   Clock_in  in   system clock, rising-edge
//   nReset    in   asynchronous active-low reset
//   Enable    in   1 = measure, 0 = return to IDLE and clear Timeout
//   Sig_in    in   measured signal (asynchronous)
//   Period    out  cycles between the last two rising edges of Sig_in
//   High_time out  cycles Sig_in was high within that period
//   Valid     out  one-cycle pulse when Period / High_time update
//   Timeout   out  sticky: no rising edge within TIMEOUT_CYCLES
//   Busy      out  state is not IDLE
// -----------------------------------------------------------------------------
module clock_period_meter #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  localparam int unsigned W             = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic         Clock_in,
  input  logic         nReset,
  input  logic         Enable,
  input  logic         Sig_in,
  output logic [W-1:0] Period,
  output logic [W-1:0] High_time,
  output logic         Valid,
  output logic         Timeout,
  output logic         Busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [W-1:0] CNT_LAST = W'(TIMEOUT_CYCLES - 1);
  localparam logic [W-1:0] CNT_ONE  = W'(1);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_dly_q, s_dly_d;
  logic [W-1:0]           cntr_q, cntr_d;
  logic [W-1:0]           hcnt_q, hcnt_d;
  logic [W-1:0]           period_q, period_d;
  logic [W-1:0]           high_q, high_d;
  logic                   valid_q, valid_d;
  logic                   timeout_q, timeout_d;
  logic                   busy_q, busy_d;

  logic                   s;
  logic                   rise;

  // Synchronizer and edge detector. The chain runs regardless of Enable so
  // that re-enabling never sees a stale level.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], Sig_in};
    s       = sync_q[SYNC_STAGES-1];
    s_dly_d = s;
    rise    = s & ~s_dly_q;
  end

  // Next-state and datapath. A rise in MEASURE takes priority over the
  // timeout check, so a period of exactly TIMEOUT_CYCLES is still reported.
  always_comb begin
    state_d   = state_q;
    cntr_d    = cntr_q;
    hcnt_d    = hcnt_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;

    if (!Enable) begin
      state_d   = IDLE;
      cntr_d    = '0;
      hcnt_d    = '0;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ARM;
        end

        ARM: begin
          // First rise only starts the count; nothing to report yet.
          if (rise) begin
            cntr_d  = '0;
            hcnt_d  = CNT_ONE;
            state_d = MEASURE;
          end
        end

        MEASURE: begin
          if (rise) begin
            period_d  = cntr_q + CNT_ONE;
            high_d    = hcnt_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            cntr_d    = '0;
            // The rise cycle itself has s high, so the new high count starts at 1.
            hcnt_d    = CNT_ONE;
          end else if (cntr_q == CNT_LAST) begin
            timeout_d = 1'b1;
            state_d   = ARM;
            cntr_d    = '0;
            hcnt_d    = '0;
          end else begin
            cntr_d = cntr_q + CNT_ONE;
            hcnt_d = hcnt_q + W'(s);
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clock_in or negedge nReset) begin
    if (!nReset) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      s_dly_q   <= 1'b0;
      cntr_q    <= '0;
      hcnt_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      s_dly_q   <= s_dly_d;
      cntr_q    <= cntr_d;
      hcnt_q    <= hcnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
    end
  end

  assign Period    = period_q;
  assign High_time = high_q;
  assign Valid     = valid_q;
  assign Timeout   = timeout_q;
  assign Busy      = busy_q;

endmodule

// File: doc/clock_period_meter.md
Name: clock_period_meter

Overview:
- Receive-side companion to the clock divider: measures a slow, asynchronous clock or tick (for example a divided clock) against the fast system clock.
- Reports the period and high time of the measured signal in system-clock cycles, with a valid pulse per measurement and a timeout flag when the signal stops.
- Used to self-check divider outputs and to report board-level clock rates.

Parameters:
- SYNC_STAGES, 2, number of flip-flop stages in the Sig_in synchronizer (minimum 2).
- TIMEOUT_CYCLES, 50_000_000, number of system cycles without a rising edge before Timeout is declared (1 s at 50 MHz).
- W (localparam), $clog2(TIMEOUT_CYCLES+1), width of the counters and result ports.

Ports:
- Clock_in  input  1  system clock; all logic is on its rising edge.
- nReset  input  1  asynchronous, active-low reset.
- Enable  input  1  1 = measure; 0 = force IDLE.
- Sig_in  input  1  signal being measured; asynchronous to Clock_in.
- Period  output  W  Clock_in cycles between the last two rising edges of Sig_in.
- High_time  output  W  Clock_in cycles Sig_in was high within that period.
- Valid  output  1  one-cycle pulse when Period and High_time update.
- Timeout  output  1  sticky flag: no edge seen within TIMEOUT_CYCLES.
- Busy  output  1  1 whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous, nReset=0): state=IDLE; synchronizer, edge register, cntr and hcnt = 0; Period=0, High_time=0, Valid=0, Timeout=0, Busy=0.
- Synchronizer: Sig_in passes through SYNC_STAGES flip-flops to give s. A rising edge is rise = s & ~s_d, where s_d is s delayed one cycle. rise is asserted SYNC_STAGES+1 cycles after a clean Sig_in rising edge.
- States:
  - IDLE: Enable=1 moves to ARM next cycle.
  - ARM: wait for the first rise. On rise: cntr<=0, hcnt<=1, go to MEASURE, no Valid.
  - MEASURE: cntr increments each cycle. hcnt<=hcnt+s each cycle.
- Rise while in MEASURE:
  - Period<=cntr+1 and High_time<=hcnt. For rises N cycles apart, Period=N, and High_time equals the number of cycles s was high.
  - Valid=1 for exactly that one cycle.
  - Timeout<=0, cntr<=0, hcnt<=1; state stays MEASURE.
- Timeout: in MEASURE with no rise and cntr==TIMEOUT_CYCLES-1:
  - Timeout<=1 and state goes to ARM.
  - Period and High_time hold their values; no Valid.
  - Timeout stays set until the next Valid, Enable=0, or reset.
  - If rise and the timeout condition occur in the same cycle, the rise wins: normal measurement, no Timeout.
- Enable=0, in any state:
  - Next cycle: state=IDLE, cntr=0, hcnt=0, Timeout=0.
  - Period and High_time hold their last values; Valid=0.
  - Re-enabling always starts in ARM, so the first period after enable is never reported.
- A constant-high Sig_in gives no rise, so it produces a Timeout, not a measurement.
- cntr never exceeds TIMEOUT_CYCLES-1, so the counters cannot wrap.
- Busy = (state != IDLE), registered.
- Reset asserted mid-measurement returns every output to its reset value immediately; no partial result is emitted.

Test Plan (bench overrides TIMEOUT_CYCLES=1000, SYNC_STAGES=2):
- Reset then Enable=1; Sig_in square wave, period 10 cycles, high 5 -> no Valid on the first rise; from the second rise, Valid pulses every 10 cycles with Period=10, High_time=5, Timeout=0.
- Sig_in period 7, high 2 -> Period=7, High_time=2. Change to period 20, high 15 -> the first Valid after the change spans the transition (Period = cycles between those two rises); all subsequent Valids report 20/15.
- Sig_in stops low after a measurement -> Timeout=1 exactly 1000 cycles after the last rise; Period holds 10. Restart the square wave -> first rise only re-arms; second rise gives Valid with Timeout cleared.
- Rise arriving on the same cycle as cntr==999 -> Valid with Period=1000, Timeout stays 0.
- Enable dropped mid-period -> next cycle Busy=0, Timeout=0, no Valid, Period holds. Re-enable -> two rises are needed before the first Valid.
- nReset pulsed low mid-MEASURE, asynchronous to Clock_in -> Period, High_time, Valid, Timeout and Busy all read 0 immediately; measurement resumes via ARM after release.
